stream_mux_4to1: RTL and testbench
==================================

# stream_mux_4to1

Four-input to one-output streaming multiplexer with round-robin arbitration and packet locking. It merges four valid/ready source streams into one registered output stream and reports which source each output beat came from. It is the merge-side counterpart to the 1-to-4 demultiplexer: traffic fanned out by a demux is recombined here before it reaches a shared single-port consumer.

## Interface
- WIDTH, 8, data width of each beat in bits (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  4*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH]
- in_last  input  4  per-source end-of-packet flag
- in_valid  input  4  per-source beat valid
- in_ready  output  4  per-source beat accepted (combinational)
- out_data  output  WIDTH  registered output beat
- out_last  output  1  registered end-of-packet flag
- out_sel  output  2  index of the source that produced the current output beat
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat

## Operation
- Handshake on every port: a beat transfers on a rising clk edge when valid and ready are both 1. Sources must hold data/last/valid stable until accepted. Downstream must tolerate out_valid held high.
- Output register: one entry holding out_data, out_last, out_sel, out_valid. Define can_load = ~out_valid | out_ready.
- Round-robin pointer ptr[1:0] holds the last granted index. Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4). The first source in that order with in_valid=1 is the candidate g.
- State machine (2 states):
  - IDLE: every source is eligible. If any in_valid is set and can_load=1, then in_ready[g]=1, the beat loads, and ptr←g. If in_last[g]=0, go to LOCKED with owner=g. Otherwise stay in IDLE.
  - LOCKED: only the owner is eligible. The other sources see in_ready=0 regardless of valid. If in_valid[owner]=1 and can_load=1, then in_ready[owner]=1 and the beat loads. If that beat has in_last=1, return to IDLE. ptr does not change while LOCKED.
- At most one in_ready bit is high in any cycle. in_ready is 0 for every source whose in_valid is 0.
- Load updates out_data←beat data, out_last←beat last, out_sel←source index, out_valid←1.
- If out_valid=1 and out_ready=1 with no new load, out_valid←0. out_data, out_last and out_sel keep their last values.
- If a simultaneous drain and load occur, the new beat replaces the old one in the same edge. Sustained throughput is one beat per cycle.
- When out_valid=1 and out_ready=0, the output register and all of its fields hold, and all in_ready are 0.

## Timing
- Reset values (asynchronous, while rst_n=0): out_valid=0, out_data=0, out_last=0, out_sel=0, state=IDLE, ptr=3 so that source 0 has first priority. in_ready=0 throughout reset.
- Latency: a beat accepted at edge N is presented on the output immediately after edge N, as out_valid=1 in cycle N+1.
- Combinational paths: in_valid→in_ready, and out_ready→in_ready. There is no combinational path from any input to out_*.
- Fairness: under continuous all-source requests of single-beat packets, the grant order is 0,1,2,3,0… Each source waits at most 3 packets.
- Reset mid-packet: the lock is dropped, any held output beat is discarded, and ptr returns to 3. The partial packet is lost and no recovery is attempted.
- A source that deasserts in_valid while LOCKED owner stalls the output. The lock is held until that source's last beat arrives.

## Test plan
- Reset: assert rst_n=0 mid-cycle with out_valid=1. Required: out_valid, out_data, out_last and out_sel drop to 0 immediately and asynchronously; all in_ready=0. After release, a single beat on source 2 goes out first, with out_sel=2.
- Single source streaming: source 1 sends 0xA1 then 0xA2, both with last=1, with out_ready=1. Required: in_ready[1] is high for 2 consecutive cycles; out_data is 0xA1 then 0xA2 on back-to-back cycles; out_sel=1 on both; latency is 1 cycle.
- Round robin: all four sources continuously present single-beat packets (data 0x10+i) with out_ready=1. Required: out_sel sequence 0,1,2,3,0,1; no source is granted twice in any 4 consecutive beats.
- Packet lock: source 1 sends a 3-beat packet 0xB0, 0xB1, 0xB2(last) while source 2 holds valid with 0xC0. Required: output shows 0xB0, 0xB1, 0xB2 with out_sel=1 and out_last only on 0xB2; 0xC0 appears next with out_sel=2; in_ready[2]=0 during the packet.
- Backpressure: load 0x55 from source 3, then hold out_ready=0 for 3 cycles while sources 0 and 3 are valid. Required: out_data=0x55 and out_valid=1 held, all in_ready=0. On out_ready=1, a new beat loads in the same edge and no beat is lost or duplicated.
- Reset mid-packet: source 0 is mid-packet with 2 of 4 beats sent, source 1 is valid, and rst_n pulses low. Required: the next accepted beat comes from source 0 per ptr=3 if it is valid, otherwise from source 1. The state is IDLE with no lock carried over.

Source files
------------

// File: rtl/stream_mux_4to1.sv
// Four-source valid/ready stream merge with round-robin arbitration and packet locking.
// The output beat is registered; in_ready is the only combinational output.
module stream_mux_4to1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*WIDTH-1:0]   in_data,
  input  logic [3:0]           in_last,
  input  logic [3:0]           in_valid,
  output logic [3:0]           in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [1:0]           out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned N_SRC = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               last_q, last_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;

  logic               can_load;
  logic               cand_found;
  logic [SEL_W-1:0]   cand;
  logic               grant_vld;
  logic [SEL_W-1:0]   grant_idx;
  logic [WIDTH-1:0]   grant_data;
  logic               grant_last;

  // Round-robin candidate: first valid source after the last granted index.
  always_comb begin
    logic [SEL_W-1:0] idx;
    cand_found = 1'b0;
    cand       = ptr_q;
    idx        = ptr_q;
    for (int k = 1; k <= int'(N_SRC); k++) begin
      idx = ptr_q + SEL_W'(k);
      if (!cand_found && in_valid[idx]) begin
        cand_found = 1'b1;
        cand       = idx;
      end
    end
  end

  assign can_load = ~valid_q | out_ready;

  // Arbitration, lock tracking and output register next-state.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    data_d     = data_q;
    last_d     = last_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    in_ready   = '0;
    grant_vld  = 1'b0;
    grant_idx  = cand;
    grant_data = '0;
    grant_last = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cand_found && can_load) begin
          grant_vld = 1'b1;
          grant_idx = cand;
          ptr_d     = cand;
          if (!in_last[cand]) begin
            state_d = ST_LOCKED;
            owner_d = cand;
          end
        end
      end
      ST_LOCKED: begin
        if (in_valid[owner_q] && can_load) begin
          grant_vld = 1'b1;
          grant_idx = owner_q;
          if (in_last[owner_q]) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Hold off all handshakes while reset is asserted.
    if (!rst_n) begin
      grant_vld = 1'b0;
    end

    for (int i = 0; i < int'(N_SRC); i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
        grant_last = in_last[i];
      end
    end

    if (grant_vld) begin
      in_ready[grant_idx] = 1'b1;
      data_d  = grant_data;
      last_d  = grant_last;
      sel_d   = grant_idx;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= SEL_W'(N_SRC - 1);
      owner_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_4to1.sv
// Directed bench for stream_mux_4to1: reset, streaming, round robin, locking, backpressure.
module tb_stream_mux_4to1;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int n_checks;
  int n_fail;

  stream_mux_4to1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [7:0] d, input logic l, input logic v);
    in_data[i*8 +: 8] = d;
    in_last[i]        = l;
    in_valid[i]       = v;
  endtask

  task automatic clear_srcs();
    in_data  = '0;
    in_last  = '0;
    in_valid = '0;
  endtask

  task automatic apply_reset();
    clear_srcs();
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_srcs();
    in_valid  = 4'hF;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    n_checks++;
    if ({out_valid, out_last, out_sel, out_data} !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b l=%b s=%0d d=%h expected all 0", out_valid, out_last, out_sel, out_data);
    end
    clear_srcs();
    #2 rst_n = 1'b1;
    step();
    // Load a beat and hold it, then reset mid-cycle.
    set_src(1, 8'h77, 1'b1, 1'b1);
    out_ready = 1'b0;
    step();
    set_src(1, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      n_fail++; $display("FAIL reset_preload: got v=%b d=%h expected v=1 d=77", out_valid, out_data);
    end
    in_valid = 4'b1111;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_last, out_sel, out_data} !== 12'h000) begin
      n_fail++; $display("FAIL reset_async_outputs: got v=%b l=%b s=%0d d=%h expected all 0", out_valid, out_last, out_sel, out_data);
    end
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_async_in_ready: got %b expected 0000", in_ready); end
    clear_srcs();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    set_src(2, 8'h22, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL reset_first_ready: got %b expected 0100", in_ready); end
    step();
    clear_srcs();
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'h22) begin
      n_fail++; $display("FAIL reset_first_beat: got v=%b s=%0d d=%h expected v=1 s=2 d=22", out_valid, out_sel, out_data);
    end
    step();
  endtask

  task automatic test_single_stream();
    logic [7:0] exp_d [2];
    exp_d[0] = 8'hA1;
    exp_d[1] = 8'hA2;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_src(1, exp_d[k], 1'b1, 1'b1);
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready%0d: got %b expected 0010", k, in_ready); end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== exp_d[k] || out_last !== 1'b1) begin
        n_fail++; $display("FAIL single_beat%0d: got v=%b s=%0d d=%h l=%b expected v=1 s=1 d=%h l=1", k, out_valid, out_sel, out_data, out_last, exp_d[k]);
      end
    end
    clear_srcs();
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL single_idle_ready: got %b expected 0000", in_ready); end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_s;
    apply_reset();
    for (int i = 0; i < 4; i++) set_src(i, 8'(8'h10 + i), 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      exp_s = 2'(k);
      #1;
      n_checks++;
      if (in_ready !== 4'(1 << exp_s)) begin n_fail++; $display("FAIL rr_ready%0d: got %b expected %b", k, in_ready, 4'(1 << exp_s)); end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== exp_s || out_data !== 8'(8'h10 + exp_s)) begin
        n_fail++; $display("FAIL rr_beat%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h", k, out_valid, out_sel, out_data, exp_s, 8'(8'h10 + exp_s));
      end
    end
    clear_srcs();
    step();
  endtask

  task automatic test_packet_lock();
    logic [7:0] pkt [3];
    pkt[0] = 8'hB0;
    pkt[1] = 8'hB1;
    pkt[2] = 8'hB2;
    apply_reset();
    set_src(2, 8'hC0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      set_src(1, pkt[k], (k == 2), 1'b1);
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_ready%0d: got %b expected 0010", k, in_ready); end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== pkt[k] || out_last !== (k == 2)) begin
        n_fail++; $display("FAIL lock_beat%0d: got v=%b s=%0d d=%h l=%b expected v=1 s=1 d=%h l=%b", k, out_valid, out_sel, out_data, out_last, pkt[k], (k == 2));
      end
    end
    set_src(1, 8'h00, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_release_ready: got %b expected 0100", in_ready); end
    step();
    clear_srcs();
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hC0 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL lock_next_pkt: got v=%b s=%0d d=%h l=%b expected v=1 s=2 d=c0 l=1", out_valid, out_sel, out_data, out_last);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    set_src(3, 8'h55, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_load_ready: got %b expected 1000", in_ready); end
    step();
    out_ready = 1'b0;
    set_src(3, 8'h56, 1'b1, 1'b1);
    set_src(0, 8'h0A, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready%0d: got %b expected 0000", k, in_ready); end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55 || out_sel !== 2'd3) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h s=%0d expected v=1 d=55 s=3", k, out_valid, out_data, out_sel);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_resume_ready: got %b expected 0001", in_ready); end
    step();
    set_src(0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h0A || out_sel !== 2'd0) begin
      n_fail++; $display("FAIL bp_resume_beat: got v=%b d=%h s=%0d expected v=1 d=0a s=0", out_valid, out_data, out_sel);
    end
    step();
    clear_srcs();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h56 || out_sel !== 2'd3) begin
      n_fail++; $display("FAIL bp_second_beat: got v=%b d=%h s=%0d expected v=1 d=56 s=3", out_valid, out_data, out_sel);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 1'b1;
    set_src(1, 8'hE0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      set_src(0, 8'(8'hD0 + k), 1'b0, 1'b1);
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rmp_ready%0d: got %b expected 0001", k, in_ready); end
      step();
    end
    set_src(0, 8'hD2, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmp_discard: got v=%b expected 0", out_valid); end
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rmp_src0_first: got %b expected 0001", in_ready); end
    set_src(0, 8'h00, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL rmp_no_lock: got %b expected 0010", in_ready); end
    step();
    clear_srcs();
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'hE0) begin
      n_fail++; $display("FAIL rmp_next_beat: got v=%b s=%0d d=%h expected v=1 s=1 d=e0", out_valid, out_sel, out_data);
    end
    step();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    in_last   = '0;
    in_valid  = '0;
    test_reset();
    test_single_stream();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
